// File: rtl/core_dout_arbiter_if.sv
// Bundle of the per-core FWFT input channels and the merged tagged output stream.
// The master modport is the arbiter's view; slave is the surrounding cores/host buffer.
// Widths follow the arbiter parameters; ID_W must equal max(1, clog2(N_CORES)).
interface core_dout_arbiter_if #(
    parameter int N_CORES   = 4,
    parameter int DIN_WIDTH = 4,
    parameter int ID_W      = 2
);
    logic [N_CORES-1:0]           core_en;
    logic [N_CORES*DIN_WIDTH-1:0] din;
    logic [N_CORES-1:0]           empty;
    logic [N_CORES-1:0]           rd_en;
    logic [DIN_WIDTH-1:0]         dout;
    logic [ID_W-1:0]              dout_id;
    logic                         dout_valid;
    logic                         dout_last;
    logic                         dout_ready;
    logic [N_CORES-1:0]           err_timeout;
    logic                         busy;

    modport master (
        input  core_en, din, empty, dout_ready,
        output rd_en, dout, dout_id, dout_valid, dout_last, err_timeout, busy
    );

    modport slave (
        output core_en, din, empty, dout_ready,
        input  rd_en, dout, dout_id, dout_valid, dout_last, err_timeout, busy
    );
endinterface

// File: rtl/core_dout_arbiter.sv
// Round-robin packet collector: merges N_CORES FWFT result streams into one tagged stream.
// Latency: grant cycle + 1, first word on dout 2 cycles after a channel goes non-empty.
// Backpressure: pops only when the output register is free; dout_ready low stalls without timing out.
// Optional CORE_DOUT_ARB_CHECKSUM_EN appends an XOR checksum word to each packet.
module core_dout_arbiter #(
    parameter int N_CORES   = 4,
    parameter int DIN_WIDTH = 4,
    parameter int PKT_WORDS = 16,
    parameter int TIMEOUT   = 255
) (
    input logic CLK,
    input logic rst_n,
    core_dout_arbiter_if.master bus
);
    localparam int ID_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int WC_W = $clog2(PKT_WORDS + 1);
    localparam int SC_W = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] LAST_W  = WC_W'(PKT_WORDS - 1);
    localparam logic [WC_W-1:0] CSUM_W  = WC_W'(PKT_WORDS);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(TIMEOUT - 1);
`ifdef CORE_DOUT_ARB_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    state_t               state, state_nx;
    logic [ID_W-1:0]      sel, sel_nx, rr_ptr, rr_nx, grant_idx;
    logic [WC_W-1:0]      wcnt, wcnt_nx;
    logic [SC_W-1:0]      scnt, scnt_nx;
    logic [N_CORES-1:0]   err_q, err_nx, cand;
    logic                 grant_found, out_free, pop, load, ld_last;
    logic [DIN_WIDTH-1:0] sel_din, ld_dat, csum;
    logic [DIN_WIDTH-1:0] dout_q;
    logic [ID_W-1:0]      dout_id_q;
    logic                 dout_valid_q, dout_last_q;

    assign cand     = bus.core_en & ~bus.empty;
    assign sel_din  = bus.din[int'(sel)*DIN_WIDTH +: DIN_WIDTH];
    assign out_free = !dout_valid_q || bus.dout_ready;

    // First candidate strictly after rr_ptr, wrapping around the channel count.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= N_CORES; k++) begin
            if (!grant_found && cand[(int'(rr_ptr) + k) % N_CORES]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'((int'(rr_ptr) + k) % N_CORES);
            end
        end
    end

    // Next-state, pop and output-load decisions.
    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        rr_nx    = rr_ptr;
        wcnt_nx  = wcnt;
        scnt_nx  = scnt;
        err_nx   = err_q;
        pop      = 1'b0;
        load     = 1'b0;
        ld_dat   = sel_din;
        ld_last  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    sel_nx   = grant_idx;
                    wcnt_nx  = '0;
                    scnt_nx  = '0;
                    state_nx = XFER;
                end
            end
            XFER: begin
                if (CSUM_EN && wcnt == CSUM_W) begin
                    // Trailing checksum beat: no pop, waits only for the output register.
                    if (out_free) begin
                        load     = 1'b1;
                        ld_dat   = csum;
                        ld_last  = 1'b1;
                        rr_nx    = sel;
                        state_nx = IDLE;
                    end
                end else if (!bus.empty[sel]) begin
                    scnt_nx = '0;
                    if (out_free) begin
                        pop     = 1'b1;
                        load    = 1'b1;
                        wcnt_nx = wcnt + 1'b1;
                        if (wcnt == LAST_W) begin
                            ld_last = !CSUM_EN;
                            if (!CSUM_EN) begin
                                rr_nx    = sel;
                                state_nx = IDLE;
                            end
                        end
                    end
                end else if (scnt == SC_LAST) begin
                    // Channel starved too long: flag it and abandon the packet without dout_last.
                    err_nx[sel] = 1'b1;
                    rr_nx       = sel;
                    state_nx    = IDLE;
                end else begin
                    scnt_nx = scnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sel    <= '0;
            rr_ptr <= ID_W'(N_CORES - 1);
            wcnt   <= '0;
            scnt   <= '0;
            err_q  <= '0;
        end else begin
            state  <= state_nx;
            sel    <= sel_nx;
            rr_ptr <= rr_nx;
            wcnt   <= wcnt_nx;
            scnt   <= scnt_nx;
            err_q  <= err_nx;
        end
    end

    // Output register: load on pop/checksum, otherwise drain when accepted.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            dout_q       <= '0;
            dout_id_q    <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end else if (load) begin
            dout_q       <= ld_dat;
            dout_id_q    <= sel;
            dout_valid_q <= 1'b1;
            dout_last_q  <= ld_last;
        end else if (bus.dout_ready) begin
            dout_valid_q <= 1'b0;
        end
    end

`ifdef CORE_DOUT_ARB_CHECKSUM_EN
    // Running XOR of the packet's data words, restarted at every grant.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (state == IDLE && grant_found) begin
            csum <= '0;
        end else if (pop) begin
            csum <= csum ^ sel_din;
        end
    end
`else
    assign csum = '0;
`endif

    assign bus.rd_en       = pop ? (N_CORES'(1) << sel) : '0;
    assign bus.dout        = dout_q;
    assign bus.dout_id     = dout_id_q;
    assign bus.dout_valid  = dout_valid_q;
    assign bus.dout_last   = dout_last_q;
    assign bus.err_timeout = err_q;
    assign bus.busy        = (state == XFER);
endmodule

// File: tb/tb_core_dout_arbiter.sv
// Directed bench for core_dout_arbiter: FIFO models per channel, beat log, per-scenario tasks.
// N_CORES=4, DIN_WIDTH=4, PKT_WORDS=16, TIMEOUT=8.
// Packet data is 0..15 so the optional checksum word is 0.
module tb_core_dout_arbiter;
    localparam int N   = 4;
    localparam int W   = 4;
    localparam int PW  = 16;
    localparam int TO  = 8;
    localparam int IDW = 2;
`ifdef CORE_DOUT_ARB_CHECKSUM_EN
    localparam int BEATS = PW + 1;
`else
    localparam int BEATS = PW;
`endif

    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    always #5 CLK = ~CLK;

    core_dout_arbiter_if #(.N_CORES(N), .DIN_WIDTH(W), .ID_W(IDW)) bus ();

    core_dout_arbiter #(.N_CORES(N), .DIN_WIDTH(W), .PKT_WORDS(PW), .TIMEOUT(TO)) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Channel FIFO models (FWFT).
    logic [W-1:0] mem [N][256];
    logic [7:0]   head [N] = '{default: '0};
    logic [7:0]   tail [N] = '{default: '0};

    always_comb begin
        bus.empty = '1;
        bus.din   = '0;
        for (int i = 0; i < N; i++) begin
            bus.empty[i]       = (head[i] == tail[i]);
            bus.din[i*W +: W]  = mem[i][head[i]];
        end
    end

    always @(posedge CLK) begin
        for (int i = 0; i < N; i++)
            if (bus.rd_en[i]) head[i] <= head[i] + 8'd1;
    end

    // Accepted-beat log.
    logic [W-1:0]   log_dat [1024];
    logic [IDW-1:0] log_id  [1024];
    logic           log_last[1024];
    int             nlog = 0;

    always @(negedge CLK) begin
        if (bus.dout_valid && bus.dout_ready) begin
            log_dat[nlog]  <= bus.dout;
            log_id[nlog]   <= bus.dout_id;
            log_last[nlog] <= bus.dout_last;
            nlog           <= nlog + 1;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input int c, input int v);
        mem[c][tail[c]] = W'(v);
        tail[c] = tail[c] + 8'd1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_beats(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (nlog >= target && !bus.busy && !bus.dout_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.core_en    = '0;
        bus.dout_ready = 1'b1;
        rst_n          = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.dout_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", bus.dout_valid);
        end
        checks++;
        if ({bus.dout, bus.dout_id, bus.dout_last} !== '0) begin
            errors++; $display("FAIL reset_dout: got %h/%h/%b expected 0/0/0", bus.dout, bus.dout_id, bus.dout_last);
        end
        checks++;
        if ({bus.rd_en, bus.err_timeout, bus.busy} !== '0) begin
            errors++; $display("FAIL reset_ctrl: got rd_en=%b err=%b busy=%b expected all 0", bus.rd_en, bus.err_timeout, bus.busy);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_packet();
        int base, run, maxrun, bad;
        base = nlog; run = 0; maxrun = 0; bad = 0;
        bus.core_en = 4'b1111;
        for (int w = 0; w < PW; w++) push(2, w);
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                checks++;
                if ({bus.busy, bus.dout_valid} !== 2'b10) begin
                    errors++; $display("FAIL grant_cycle: got busy=%b valid=%b expected busy=1 valid=0", bus.busy, bus.dout_valid);
                end
            end
            if (k == 2) begin
                checks++;
                if ({bus.dout_valid, bus.dout, bus.dout_id} !== {1'b1, 4'h0, 2'd2}) begin
                    errors++; $display("FAIL first_word_latency: got valid=%b dout=%h id=%0d expected 1/0/2", bus.dout_valid, bus.dout, bus.dout_id);
                end
            end
            if (bus.rd_en == 4'b0100) begin
                run++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
                if (bus.rd_en != 4'b0000) bad++;
            end
        end
        checks++;
        if (maxrun != PW || bad != 0) begin
            errors++; $display("FAIL single_rd_en_run: got run=%0d stray=%0d expected %0d/0", maxrun, bad, PW);
        end
        checks++;
        if (nlog - base != BEATS || bus.busy !== 1'b0) begin
            errors++; $display("FAIL single_beats: got %0d beats busy=%b expected %0d beats busy=0", nlog - base, bus.busy, BEATS);
        end
        for (int w = 0; w < BEATS; w++) begin
            checks++;
            if ({log_id[base+w], log_dat[base+w], log_last[base+w]} !== {2'd2, W'((w < PW) ? w : 0), w == BEATS - 1}) begin
                errors++; $display("FAIL single_beat%0d: got id=%0d dat=%h last=%b", w, log_id[base+w], log_dat[base+w], log_last[base+w]);
            end
        end
    endtask

    task automatic test_round_robin();
        int base;
        bit ok;
        logic [IDW-1:0] exp_id;
        do_reset();
        base = nlog;
        bus.core_en = 4'b1111;
        for (int w = 0; w < 2 * PW; w++) push(0, w % PW);
        for (int c = 1; c < N; c++)
            for (int w = 0; w < PW; w++) push(c, w);
        wait_beats(base + 5 * BEATS, 400, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL rr_done: got %0d beats expected %0d", nlog - base, 5 * BEATS);
        end
        for (int p = 0; p < 5; p++) begin
            exp_id = IDW'(p % 4);
            for (int w = 0; w < BEATS; w++) begin
                checks++;
                if ({log_id[base+p*BEATS+w], log_dat[base+p*BEATS+w], log_last[base+p*BEATS+w]} !== {exp_id, W'((w < PW) ? w : 0), w == BEATS - 1}) begin
                    errors++; $display("FAIL rr_pkt%0d_beat%0d: got id=%0d dat=%h last=%b expected id=%0d", p, w, log_id[base+p*BEATS+w], log_dat[base+p*BEATS+w], log_last[base+p*BEATS+w], exp_id);
                end
            end
        end
    endtask

    task automatic test_mask();
        int base;
        bit ok;
        logic [IDW-1:0] exp_id;
        do_reset();
        base = nlog;
        bus.core_en = 4'b1011;
        for (int c = 0; c < N; c++)
            for (int w = 0; w < PW; w++) push(c, w);
        wait_beats(base + 3 * BEATS, 300, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL mask_done: got %0d beats expected %0d", nlog - base, 3 * BEATS);
        end
        for (int p = 0; p < 3; p++) begin
            exp_id = (p == 2) ? 2'd3 : IDW'(p);
            for (int w = 0; w < BEATS; w++) begin
                checks++;
                if ({log_id[base+p*BEATS+w], log_dat[base+p*BEATS+w]} !== {exp_id, W'((w < PW) ? w : 0)}) begin
                    errors++; $display("FAIL mask_pkt%0d_beat%0d: got id=%0d dat=%h expected id=%0d", p, w, log_id[base+p*BEATS+w], log_dat[base+p*BEATS+w], exp_id);
                end
            end
        end
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if ({bus.busy, bus.rd_en} !== 5'b0 || tail[2] - head[2] != 8'd16) begin
            errors++; $display("FAIL mask_ch2_untouched: got busy=%b rd_en=%b ch2_level=%0d expected 0/0000/16", bus.busy, bus.rd_en, tail[2] - head[2]);
        end
        bus.core_en = 4'b0100;
        wait_beats(base + 4 * BEATS, 100, ok);
        checks++;
        if (!ok || head[2] != tail[2] || log_id[base+3*BEATS] !== 2'd2) begin
            errors++; $display("FAIL mask_drain: got ok=%b ch2_level=%0d id=%0d expected 1/0/2", ok, tail[2] - head[2], log_id[base+3*BEATS]);
        end
    endtask

    task automatic test_backpressure();
        int base, k;
        bit ok;
        do_reset();
        base = nlog;
        bus.core_en = 4'b1111;
        for (int w = 0; w < PW; w++) push(1, w);
        k = 0;
        while (nlog - base < 5 && k < 50) begin
            tick();
            k++;
        end
        checks++;
        if (nlog - base != 5) begin
            errors++; $display("FAIL bp_prefix: got %0d beats expected 5", nlog - base);
        end
        bus.dout_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            checks++;
            if ({bus.dout_valid, bus.dout, bus.rd_en, bus.err_timeout} !== {1'b1, 4'h5, 4'b0000, 4'b0000}) begin
                errors++; $display("FAIL bp_hold%0d: got valid=%b dout=%h rd_en=%b err=%b expected 1/5/0000/0000", c, bus.dout_valid, bus.dout, bus.rd_en, bus.err_timeout);
            end
        end
        tick();
        bus.dout_ready = 1'b1;
        wait_beats(base + BEATS, 100, ok);
        checks++;
        if (!ok || nlog - base != BEATS) begin
            errors++; $display("FAIL bp_count: got %0d beats expected %0d", nlog - base, BEATS);
        end
        for (int w = 0; w < BEATS; w++) begin
            checks++;
            if ({log_id[base+w], log_dat[base+w], log_last[base+w]} !== {2'd1, W'((w < PW) ? w : 0), w == BEATS - 1}) begin
                errors++; $display("FAIL bp_beat%0d: got id=%0d dat=%h last=%b", w, log_id[base+w], log_dat[base+w], log_last[base+w]);
            end
        end
    endtask

    task automatic test_timeout();
        int base, cnt, k;
        bit ok;
        do_reset();
        base = nlog;
        bus.core_en = 4'b1111;
        for (int w = 1; w <= 5; w++) push(1, w);
        for (int w = 0; w < PW; w++) push(2, w);
        cnt = 0; k = 0;
        while (cnt < 5 && k < 40) begin
            @(negedge CLK);
            if (bus.rd_en[1]) cnt++;
            k++;
        end
        checks++;
        if (cnt != 5) begin
            errors++; $display("FAIL to_pops: got %0d pops expected 5", cnt);
        end
        for (int j = 1; j <= 9; j++) begin
            @(negedge CLK);
            if (j == 8) begin
                checks++;
                if (bus.err_timeout !== 4'b0000) begin
                    errors++; $display("FAIL to_early: got err=%b expected 0000", bus.err_timeout);
                end
            end
            if (j == 9) begin
                checks++;
                if ({bus.err_timeout, bus.busy} !== {4'b0010, 1'b0}) begin
                    errors++; $display("FAIL to_flag: got err=%b busy=%b expected 0010/0", bus.err_timeout, bus.busy);
                end
            end
        end
        wait_beats(base + 5 + BEATS, 100, ok);
        checks++;
        if (!ok || bus.err_timeout !== 4'b0010) begin
            errors++; $display("FAIL to_next: got ok=%b err=%b expected 1/0010", ok, bus.err_timeout);
        end
        for (int w = 0; w < 5; w++) begin
            checks++;
            if ({log_id[base+w], log_dat[base+w], log_last[base+w]} !== {2'd1, W'(w + 1), 1'b0}) begin
                errors++; $display("FAIL to_beat%0d: got id=%0d dat=%h last=%b", w, log_id[base+w], log_dat[base+w], log_last[base+w]);
            end
        end
        for (int w = 0; w < BEATS; w++) begin
            checks++;
            if ({log_id[base+5+w], log_dat[base+5+w], log_last[base+5+w]} !== {2'd2, W'((w < PW) ? w : 0), w == BEATS - 1}) begin
                errors++; $display("FAIL to_ch2_beat%0d: got id=%0d dat=%h last=%b", w, log_id[base+5+w], log_dat[base+5+w], log_last[base+5+w]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        int base, k;
        logic [7:0] h3;
        base = nlog;
        bus.core_en = 4'b1111;
        for (int w = 0; w < PW; w++) push(3, w);
        k = 0;
        while (nlog - base < 4 && k < 30) begin
            tick();
            k++;
        end
        checks++;
        if (nlog - base != 4 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL rst_mid_setup: got %0d beats busy=%b expected 4/1", nlog - base, bus.busy);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.dout_valid, bus.dout, bus.dout_id, bus.dout_last} !== '0) begin
            errors++; $display("FAIL rst_mid_dout: got valid=%b dout=%h id=%0d last=%b expected all 0", bus.dout_valid, bus.dout, bus.dout_id, bus.dout_last);
        end
        checks++;
        if ({bus.rd_en, bus.busy, bus.err_timeout} !== '0) begin
            errors++; $display("FAIL rst_mid_ctrl: got rd_en=%b busy=%b err=%b expected all 0", bus.rd_en, bus.busy, bus.err_timeout);
        end
        h3 = head[3];
        for (int c = 0; c < 3; c++) tick();
        checks++;
        if (head[3] != h3 || bus.rd_en !== 4'b0000) begin
            errors++; $display("FAIL rst_mid_nopop: got head=%0d rd_en=%b expected head=%0d rd_en=0000", head[3], bus.rd_en, h3);
        end
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_mask();
        test_backpressure();
        test_timeout();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
